multicycle_control: RTL

Multi-cycle successor to the single-cycle MISC-V control decoder. It keeps the same opcode/func decode, but sequences each instruction through a FETCH/DECODE/EXEC/MEM/WB state machine. It adds a latched instruction register, a variable-latency memory handshake with timeout, illegal-instruction trapping and a retired-instruction counter. It sits between the instruction source, the datapath (ALU, register file, PC) and data memory.

---
 rtl/multicycle_control.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle MISC-V controller: sequences each instruction through FETCH/DECODE/EXEC/MEM/WB,
// with a latched IR, a timed memory handshake, illegal-instruction trapping and a retire counter.
module multicycle_control #(
    parameter int OPCODE_W    = 3,
    parameter int FUNC_W      = 4,
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                instr_valid,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNC_W-1:0]   func,
    input  logic                mem_ready,
    output logic                instr_ready,
    output logic                RegWrite,
    output logic                ALUsrc,
    output logic                MemWrite,
    output logic                MemRead,
    output logic                Branch,
    output logic                JumpOut,
    output logic [ALUOP_W-1:0]  ALUop,
    output logic [1:0]          RegStore,
    output logic                PCWrite,
    output logic [2:0]          state,
    output logic                fault,
    output logic [CNT_W-1:0]    retired
);

    typedef enum logic [2:0] {
        S_UNUSED0 = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXEC      = 3'd3,
        MEM       = 3'd4,
        WB        = 3'd5,
        FAULT     = 3'd6,
        S_UNUSED7 = 3'd7
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_I    = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_BR0  = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_BR1  = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_JIN  = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_JOUT = OPCODE_W'(7);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t               r_state;
    state_t               w_nextState;
    logic [OPCODE_W-1:0]  r_irOp;
    logic [FUNC_W-1:0]    r_irFunc;
    logic [WAIT_W-1:0]    r_waitCnt;
    logic [CNT_W-1:0]     r_retired;
    logic [ALUOP_W-1:0]   w_aluOpDec;
    logic                 w_retire;
    logic                 w_illegal;
    logic                 w_isLoad;

    assign w_illegal = (r_irOp == OP_R) && (r_irFunc > FUNC_W'(3));
    assign w_isLoad  = (r_irOp == OP_LW);
    assign state     = r_state;
    assign retired   = r_retired;

    // ALU operation is a pure function of the IR so it stays stable from EXEC through WB
    always_comb begin
        w_aluOpDec = '0;
        case (r_irOp)
            OP_R:          w_aluOpDec = ALUOP_W'(r_irFunc[1:0]) + ALUOP_W'(1);
            OP_I: begin
                case (r_irFunc[FUNC_W-1 -: 2])
                    2'd0:    w_aluOpDec = ALUOP_W'(1);
                    2'd1:    w_aluOpDec = ALUOP_W'(5);
                    2'd2:    w_aluOpDec = ALUOP_W'(6);
                    default: w_aluOpDec = ALUOP_W'(7);
                endcase
            end
            OP_LW, OP_SW:   w_aluOpDec = ALUOP_W'(1);
            OP_BR0, OP_BR1: w_aluOpDec = ALUOP_W'(2);
            default:        w_aluOpDec = '0;
        endcase
    end

    always_comb begin
        w_nextState = r_state;
        w_retire    = 1'b0;
        instr_ready = 1'b0;
        RegWrite    = 1'b0;
        ALUsrc      = 1'b0;
        MemWrite    = 1'b0;
        MemRead     = 1'b0;
        Branch      = 1'b0;
        JumpOut     = 1'b0;
        ALUop       = '0;
        RegStore    = 2'd0;
        PCWrite     = 1'b0;
        fault       = 1'b0;
        case (r_state)
            FETCH: begin
                instr_ready = ~reset;
                if (instr_valid) w_nextState = DECODE;
            end
            DECODE: begin
                w_nextState = w_illegal ? FAULT : EXEC;
            end
            EXEC: begin
                ALUop = w_aluOpDec;
                case (r_irOp)
                    OP_R: begin
                        ALUsrc      = 1'b1;
                        w_nextState = WB;
                    end
                    OP_I:         w_nextState = WB;
                    OP_LW, OP_SW: w_nextState = MEM;
                    default: begin
                        Branch      = 1'b1;
                        PCWrite     = 1'b1;
                        RegStore    = (r_irOp == OP_JIN) ? 2'd2 : 2'd0;
                        JumpOut     = (r_irOp == OP_JOUT);
                        w_retire    = 1'b1;
                        w_nextState = FETCH;
                    end
                endcase
            end
            MEM: begin
                ALUop    = w_aluOpDec;
                MemRead  = w_isLoad;
                MemWrite = ~w_isLoad;
                // A response arriving on the final allowed cycle still wins over the timeout
                if (mem_ready) begin
                    if (w_isLoad) begin
                        w_nextState = WB;
                    end else begin
                        PCWrite     = 1'b1;
                        w_retire    = 1'b1;
                        w_nextState = FETCH;
                    end
                end else if (r_waitCnt == WAIT_LAST) begin
                    w_nextState = FAULT;
                end
            end
            WB: begin
                ALUop       = w_aluOpDec;
                RegWrite    = 1'b1;
                PCWrite     = 1'b1;
                RegStore    = w_isLoad ? 2'd0 : 2'd1;
                w_retire    = 1'b1;
                w_nextState = FETCH;
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: begin
                w_nextState = FAULT;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state   <= FETCH;
            r_irOp    <= '0;
            r_irFunc  <= '0;
            r_waitCnt <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == FETCH && instr_valid) begin
                r_irOp   <= opcode;
                r_irFunc <= func;
            end
            // Stall counter is held at zero everywhere but MEM, so it restarts on each entry
            if (r_state == MEM && !mem_ready) r_waitCnt <= r_waitCnt + 1'b1;
            else                              r_waitCnt <= '0;
            if (w_retire) r_retired <= r_retired + 1'b1;
        end
    end

endmodule
